erasable_cycle_seq: RTL and testbench

//  Erasable-memory cycle sequencer. It sits directly downstream of the S-register/parity stage.
//  It consumes S01..S12 plus the EB9..EB11 bank bits, and maps them to an 11-bit core address.
//  It then runs a destructive-read / strobe / hold / write-back cycle against the core model.
//  The sensed word (15 data + parity bit 16) returns on rdata for the G-register load and odd-parity check.

---
 rtl/erasable_cycle_seq.sv | 182 ++++++++++++++++++
 tb/tb_erasable_cycle_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/erasable_cycle_seq.sv
// erasable_cycle_seq
//   Erasable-memory cycle sequencer. Decodes the S register plus EB bank bits
//   into an 11-bit core address and runs a destructive-read / sense strobe /
//   hold / write-back cycle against the core model. The sensed word (15 data
//   bits + parity in bit 15) is returned on rdata with an odd-parity check.
//
// Ports
//   CLOCK       in   system clock, rising edge
//   rst_        in   asynchronous active-low reset
//   mct_start   in   one-cycle memory cycle request
//   s_addr      in   S register (bit0 = S01 .. bit11 = S12)
//   eb          in   erasable bank (bit0 = EB9 .. bit2 = EB11)
//   sense_data  in   core sense-amp word, bit15 = parity
//   wr_req      in   end of HOLD: 1 = write wdata, 0 = restore rdata
//   wdata       in   replacement word incl. parity
//   chk_en      in   parity check enable
//   alarm_clr   in   clears par_alarm
//   mem_addr    out  latched core address
//   mem_rd      out  read/erase drive
//   mem_wr      out  write/inhibit drive
//   mem_wdata   out  write-back word
//   rdata       out  captured sense word
//   rdata_vld   out  pulse: rdata newly captured
//   par_fail    out  pulse: parity error on the captured word
//   par_alarm   out  sticky parity alarm
//   reg_sel     out  pulse: central register addressed, no core cycle
//   busy        out  sequencer not idle
module erasable_cycle_seq #(
   parameter int unsigned RD_CYC   = 2,
   parameter int unsigned HOLD_CYC = 4,
   parameter int unsigned WR_CYC   = 2
) (
   input  logic        CLOCK,
   input  logic        rst_,
   input  logic        mct_start,
   input  logic [11:0] s_addr,
   input  logic [2:0]  eb,
   input  logic [15:0] sense_data,
   input  logic        wr_req,
   input  logic [15:0] wdata,
   input  logic        chk_en,
   input  logic        alarm_clr,
   output logic [10:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [15:0] mem_wdata,
   output logic [15:0] rdata,
   output logic        rdata_vld,
   output logic        par_fail,
   output logic        par_alarm,
   output logic        reg_sel,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_HOLD,
      S_WRITE
   } state_t;

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic [10:0] mem_addr_q;
   logic [15:0] mem_wdata_q;
   logic [15:0] rdata_q;
   logic        mem_rd_q;
   logic        mem_wr_q;
   logic        rdata_vld_q;
   logic        par_fail_q;
   logic        par_alarm_q;
   logic        reg_sel_q;
   logic        busy_q;

   logic        erasable_d;
   logic        central_d;
   logic [10:0] addr_d;
   logic        bad_par_d;

   always_comb begin
      erasable_d = (s_addr[11:10] == 2'b00);
      central_d  = (s_addr[11:4] == 8'h00);
      // The top quarter of erasable space is a window onto the selected bank.
      if (s_addr[9:8] == 2'b11) begin
         addr_d = {eb, s_addr[7:0]};
      end else begin
         addr_d = {1'b0, s_addr[9:8], s_addr[7:0]};
      end
      bad_par_d = chk_en && (^sense_data == 1'b0);
   end

   always_ff @(posedge CLOCK or negedge rst_) begin
      if (!rst_) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         rdata_vld_q <= 1'b0;
         par_fail_q  <= 1'b0;
         par_alarm_q <= 1'b0;
         reg_sel_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         rdata_vld_q <= 1'b0;
         par_fail_q  <= 1'b0;
         reg_sel_q   <= 1'b0;
         // A parity failure on the same edge overrides this below.
         if (alarm_clr) begin
            par_alarm_q <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (mct_start && erasable_d) begin
                  if (central_d) begin
                     reg_sel_q <= 1'b1;
                  end else begin
                     state_q    <= S_READ;
                     cnt_q      <= '0;
                     mem_addr_q <= addr_d;
                     mem_rd_q   <= 1'b1;
                     busy_q     <= 1'b1;
                  end
               end
            end
            S_READ: begin
               if (cnt_q == 8'(RD_CYC - 1)) begin
                  state_q     <= S_HOLD;
                  cnt_q       <= '0;
                  mem_rd_q    <= 1'b0;
                  rdata_q     <= sense_data;
                  rdata_vld_q <= 1'b1;
                  if (bad_par_d) begin
                     par_fail_q  <= 1'b1;
                     par_alarm_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_HOLD: begin
               if (cnt_q == 8'(HOLD_CYC - 1)) begin
                  state_q     <= S_WRITE;
                  cnt_q       <= '0;
                  mem_wr_q    <= 1'b1;
                  mem_wdata_q <= wr_req ? wdata : rdata_q;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_WRITE: begin
               if (cnt_q == 8'(WR_CYC - 1)) begin
                  state_q  <= S_IDLE;
                  cnt_q    <= '0;
                  mem_wr_q <= 1'b0;
                  busy_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_rd    = mem_rd_q;
   assign mem_wr    = mem_wr_q;
   assign mem_wdata = mem_wdata_q;
   assign rdata     = rdata_q;
   assign rdata_vld = rdata_vld_q;
   assign par_fail  = par_fail_q;
   assign par_alarm = par_alarm_q;
   assign reg_sel   = reg_sel_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_erasable_cycle_seq.sv
// tb_erasable_cycle_seq
//   Bench for erasable_cycle_seq: directed scenarios with literal expectations
//   followed by randomized traffic, all compared every cycle against a
//   timeline model (elapsed cycles since acceptance).
module tb_erasable_cycle_seq;

   localparam int RD   = 2;
   localparam int HOLD = 4;
   localparam int WR   = 2;
   localparam int TOT  = RD + HOLD + WR;

   logic        CLOCK = 1'b0;
   logic        rst_;
   logic        mct_start;
   logic [11:0] s_addr;
   logic [2:0]  eb;
   logic [15:0] sense_data;
   logic        wr_req;
   logic [15:0] wdata;
   logic        chk_en;
   logic        alarm_clr;
   logic [10:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] mem_wdata;
   logic [15:0] rdata;
   logic        rdata_vld;
   logic        par_fail;
   logic        par_alarm;
   logic        reg_sel;
   logic        busy;

   int n_chk  = 0;
   int n_fail = 0;
   bit model_on = 1'b0;

   erasable_cycle_seq #(.RD_CYC(RD), .HOLD_CYC(HOLD), .WR_CYC(WR)) dut (
      .CLOCK(CLOCK), .rst_(rst_), .mct_start(mct_start), .s_addr(s_addr),
      .eb(eb), .sense_data(sense_data), .wr_req(wr_req), .wdata(wdata),
      .chk_en(chk_en), .alarm_clr(alarm_clr), .mem_addr(mem_addr),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .rdata(rdata),
      .rdata_vld(rdata_vld), .par_fail(par_fail), .par_alarm(par_alarm),
      .reg_sel(reg_sel), .busy(busy)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // k = cycles elapsed since the accepting edge (0 = idle).
   int          k;
   logic [10:0] m_addr;
   logic [15:0] m_rdata, m_wdata;
   logic        m_vld, m_pf, m_alarm, m_rsel;

   always @(posedge CLOCK or negedge rst_) begin
      if (!rst_) begin
         k = 0; m_addr = 0; m_rdata = 0; m_wdata = 0;
         m_vld = 0; m_pf = 0; m_alarm = 0; m_rsel = 0;
      end else begin
         m_vld = 0; m_pf = 0; m_rsel = 0;
         if (k == 0) begin
            if (mct_start && s_addr[11:10] == 2'b00) begin
               if (s_addr < 12'o0020) m_rsel = 1;
               else begin
                  k = 1;
                  if (s_addr[9:8] == 2'b11) m_addr = 11'(eb * 256 + s_addr[7:0]);
                  else m_addr = 11'(s_addr[9:0]);
               end
            end
         end else begin
            if (k == RD) begin
               m_rdata = sense_data;
               m_vld = 1;
               m_pf = chk_en && ($countones(sense_data) % 2 == 0);
            end
            if (k == RD + HOLD) m_wdata = wr_req ? wdata : m_rdata;
            k = (k == TOT) ? 0 : k + 1;
         end
         if (m_pf) m_alarm = 1;
         else if (alarm_clr) m_alarm = 0;
      end
   end

   always @(negedge CLOCK) begin
      if (model_on) begin
         chk("busy", busy, k != 0);
         chk("mem_rd", mem_rd, k >= 1 && k <= RD);
         chk("mem_wr", mem_wr, k > RD + HOLD);
         chk("rdata_vld", rdata_vld, m_vld);
         chk("par_fail", par_fail, m_pf);
         chk("par_alarm", par_alarm, m_alarm);
         chk("reg_sel", reg_sel, m_rsel);
         chk("rdata", rdata, m_rdata);
         chk("rd_wr_excl", mem_rd & mem_wr, 1'b0);
         if (k != 0) chk("mem_addr", mem_addr, m_addr);
         if (k > RD + HOLD) chk("mem_wdata", mem_wdata, m_wdata);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   // Runs one full memory cycle with literal timing checks at default
   // parameters, and a redundant request plus eb change in cycle 4.
   task automatic run_cycle(input logic [11:0] sa, input logic [2:0] e,
                            input logic [15:0] sd, input logic wrq,
                            input logic [15:0] wd, input logic ck,
                            input logic [10:0] x_addr, input logic x_fail,
                            input logic [15:0] x_wd);
      s_addr = sa; eb = e; sense_data = sd; wr_req = wrq; wdata = wd; chk_en = ck;
      mct_start = 1;
      tick();
      mct_start = 0;
      for (int c = 1; c <= 9; c++) begin
         chk("lit_mem_rd", mem_rd, c <= 2);
         chk("lit_mem_wr", mem_wr, c == 7 || c == 8);
         chk("lit_busy", busy, c <= 8);
         chk("lit_vld", rdata_vld, c == 3);
         if (c == 1) chk("lit_addr", mem_addr, x_addr);
         if (c == 3) begin
            chk("lit_rdata", rdata, sd);
            chk("lit_par_fail", par_fail, x_fail);
         end
         if (c == 7) chk("lit_wdata", mem_wdata, x_wd);
         if (c == 8) chk("lit_addr_held", mem_addr, x_addr);
         if (c == 4) begin mct_start = 1; eb = ~e; end
         if (c == 5) mct_start = 0;
         tick();
      end
   endtask

   initial begin
      rst_ = 0; mct_start = 0; s_addr = 0; eb = 0; sense_data = 0;
      wr_req = 0; wdata = 0; chk_en = 1; alarm_clr = 0;
      #2;
      model_on = 1;
      tick(); tick();
      chk("rst_busy", busy, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_par_alarm", par_alarm, 0);
      rst_ = 1;
      tick();

      // banked window, good parity, restore
      run_cycle(12'o1400, 3'b101, 16'h8000, 0, 16'h1234, 1, 11'h500, 0, 16'h8000);
      // bad parity, alarm sticks until cleared
      run_cycle(12'o0123, 3'b010, 16'h0003, 0, 16'h0000, 1, 11'h053, 1, 16'h0003);
      chk("alarm_sticky", par_alarm, 1);
      tick(); tick();
      chk("alarm_still", par_alarm, 1);
      alarm_clr = 1; tick(); alarm_clr = 0;
      chk("alarm_cleared", par_alarm, 0);
      // explicit write data
      run_cycle(12'o1777, 3'b111, 16'h0001, 1, 16'h4AAA, 1, 11'h7FF, 0, 16'h4AAA);
      // central register
      s_addr = 12'o0012; mct_start = 1; tick(); mct_start = 0;
      chk("reg_sel_pulse", reg_sel, 1);
      chk("reg_busy", busy, 0);
      chk("reg_no_rd", mem_rd, 0);
      tick();
      chk("reg_sel_once", reg_sel, 0);
      // fixed memory address: nothing happens
      s_addr = 12'o4000; mct_start = 1; tick(); mct_start = 0;
      chk("fixed_busy", busy, 0);
      chk("fixed_reg_sel", reg_sel, 0);
      tick();
      // check disabled on a bad-parity word
      run_cycle(12'o0200, 3'b000, 16'h0003, 0, 16'h0000, 0, 11'h080, 0, 16'h0003);
      chk("chk_off_alarm", par_alarm, 0);
      // reset during WRITE
      s_addr = 12'o0400; sense_data = 16'h0003; chk_en = 1; mct_start = 1;
      tick(); mct_start = 0;
      for (int c = 1; c < 7; c++) tick();
      chk("pre_rst_wr", mem_wr, 1);
      chk("pre_rst_alarm", par_alarm, 1);
      rst_ = 0; #1;
      chk("async_mem_wr", mem_wr, 0);
      chk("async_busy", busy, 0);
      chk("async_alarm", par_alarm, 0);
      tick(); rst_ = 1; tick();
      run_cycle(12'o0777, 3'b011, 16'h0100, 1, 16'h2222, 1, 11'h1FF, 0, 16'h2222);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         mct_start  = ($urandom_range(0, 2) == 0);
         s_addr     = ($urandom_range(0, 7) == 0) ? 12'($urandom) : {2'b00, 10'($urandom)};
         if ($urandom_range(0, 9) == 0) s_addr = 12'($urandom_range(0, 15));
         eb         = 3'($urandom);
         sense_data = 16'($urandom);
         wr_req     = 1'($urandom);
         wdata      = 16'($urandom);
         chk_en     = ($urandom_range(0, 4) != 0);
         alarm_clr  = ($urandom_range(0, 9) == 0);
         rst_       = ($urandom_range(0, 299) != 0);
         tick();
      end
      rst_ = 1; mct_start = 0;
      for (int i = 0; i < 12; i++) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
